// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: bus load/store issue, load alignment/extension, mem_wb and forward outputs
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access #(
  parameter int XLEN          = 64,
  parameter int ADDR_MASK_LSB = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         ex_mem_inst,
  input  logic [XLEN-1:0]     ex_mem_inst_pc,
  input  logic                ex_mem_valid,
  input  logic [XLEN-1:0]     ex_mem_alu_result,
  input  logic [XLEN-1:0]     ex_mem_write_mem_data,
  input  logic                advance,
  input  logic                flush,
  output logic [31:0]         mem_wb_inst,
  output logic [XLEN-1:0]     mem_wb_inst_pc,
  output logic                mem_wb_valid,
  output logic [XLEN-1:0]     mem_wb_result,
  output logic                forward_reg_write_enable,
  output logic [4:0]          forward_reg_dest_addr,
  output logic [XLEN-1:0]     forward_reg_write_data,
  output logic                ok,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                misalign,
`endif
  output logic                dreq_valid,
  output logic [XLEN-1:0]     dreq_addr,
  output logic [2:0]          dreq_size,
  output logic [XLEN/8-1:0]   dreq_strobe,
  output logic [XLEN-1:0]     dreq_data,
  input  logic                dresp_data_ok,
  input  logic [XLEN-1:0]     dresp_data
);

  localparam int NB = XLEN / 8;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t state, next_state;

  logic [XLEN-1:0]          req_addr_q;
  logic [1:0]               req_size_q;
  logic                     req_uns_q;
  logic                     req_is_load_q;
  logic [NB-1:0]            req_strobe_q;
  logic [XLEN-1:0]          req_data_q;
  logic [XLEN-1:0]          load_buf_q;
  logic                     killed_q;
  logic                     trap_q;

  logic [6:0]               opcode;
  logic                     is_load, is_store, is_mem, writes_rd;
  logic [1:0]               sz;
  logic                     uns;
  logic [ADDR_MASK_LSB-1:0] off;
  logic [NB-1:0]            cur_strobe;
  logic [XLEN-1:0]          cur_data;
  logic                     mis_now;

  logic                     issue, load_cap, kill_set, mis_set;
  logic [XLEN-1:0]          load_next;
  logic [XLEN-1:0]          result;

  function automatic logic [NB-1:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    size_mask = NB'(8'h01);
      2'd1:    size_mask = NB'(8'h03);
      2'd2:    size_mask = NB'(8'h0F);
      default: size_mask = NB'(8'hFF);
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [ADDR_MASK_LSB-1:0] o,
                                                  input logic [1:0] s,
                                                  input logic u);
    logic [XLEN-1:0] sh;
    sh = word >> {o, 3'b000};
    case (s)
      2'd0:    load_extend = {{(XLEN-8){sh[7] & ~u}}, sh[7:0]};
      2'd1:    load_extend = {{(XLEN-16){sh[15] & ~u}}, sh[15:0]};
      2'd2:    load_extend = {{(XLEN-32){sh[31] & ~u}}, sh[31:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign opcode     = ex_mem_inst[6:0];
  assign is_load    = (opcode == 7'b0000011);
  assign is_store   = (opcode == 7'b0100011);
  assign is_mem     = is_load | is_store;
  assign sz         = ex_mem_inst[13:12];
  assign uns        = ex_mem_inst[14];
  assign off        = ex_mem_alu_result[ADDR_MASK_LSB-1:0];
  assign cur_strobe = is_store ? (size_mask(sz) << off) : '0;
  assign cur_data   = is_store ? (ex_mem_write_mem_data << {off, 3'b000}) : '0;

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    case (sz)
      2'd0:    mis_now = 1'b0;
      2'd1:    mis_now = off[0];
      2'd2:    mis_now = |off[1:0];
      default: mis_now = |off;
    endcase
  end
  assign misalign = trap_q;
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    writes_rd = 1'b0;
    case (opcode)
      7'b0000011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_addr_q    <= '0;
      req_size_q    <= '0;
      req_uns_q     <= 1'b0;
      req_is_load_q <= 1'b0;
      req_strobe_q  <= '0;
      req_data_q    <= '0;
      load_buf_q    <= '0;
      killed_q      <= 1'b0;
      trap_q        <= 1'b0;
    end else begin
      state <= next_state;
      if (issue) begin
        req_addr_q    <= ex_mem_alu_result;
        req_size_q    <= sz;
        req_uns_q     <= uns;
        req_is_load_q <= is_load;
        req_strobe_q  <= cur_strobe;
        req_data_q    <= cur_data;
      end
      if (load_cap) load_buf_q <= load_next;
      if (kill_set) killed_q <= 1'b1;
      if (mis_set)  trap_q   <= 1'b1;
      if (next_state == IDLE) begin
        killed_q <= 1'b0;
        trap_q   <= 1'b0;
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, even if ex_mem still carries a memory op.
  always_comb begin
    next_state  = state;
    dreq_valid  = 1'b0;
    dreq_addr   = '0;
    dreq_size   = '0;
    dreq_strobe = '0;
    dreq_data   = '0;
    ok          = 1'b0;
    result      = ex_mem_alu_result;
    issue       = 1'b0;
    load_cap    = 1'b0;
    kill_set    = 1'b0;
    mis_set     = 1'b0;
    load_next   = load_extend(dresp_data, req_addr_q[ADDR_MASK_LSB-1:0], req_size_q, req_uns_q);
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (ex_mem_valid && is_mem && !flush) begin
            if (mis_now) begin
              mis_set    = 1'b1;
              next_state = DONE;
            end else begin
              issue       = 1'b1;
              dreq_valid  = 1'b1;
              dreq_addr   = ex_mem_alu_result;
              dreq_size   = {1'b0, sz};
              dreq_strobe = cur_strobe;
              dreq_data   = cur_data;
              if (dresp_data_ok) begin
                load_cap   = 1'b1;
                load_next  = load_extend(dresp_data, off, sz, uns);
                next_state = DONE;
              end else begin
                next_state = WAIT;
              end
            end
          end else begin
            ok = 1'b1;
          end
        end
        WAIT: begin
          dreq_valid  = 1'b1;
          dreq_addr   = req_addr_q;
          dreq_size   = {1'b0, req_size_q};
          dreq_strobe = req_strobe_q;
          dreq_data   = req_data_q;
          if (flush) kill_set = 1'b1;
          if (dresp_data_ok) begin
            load_cap   = 1'b1;
            next_state = (killed_q || flush) ? IDLE : DONE;
          end
        end
        DONE: begin
          ok     = 1'b1;
          result = (req_is_load_q && !trap_q) ? load_buf_q : ex_mem_alu_result;
          if (advance || flush) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign mem_wb_inst              = ex_mem_inst;
  assign mem_wb_inst_pc           = ex_mem_inst_pc;
  assign mem_wb_valid             = ex_mem_valid & ok & ~(killed_q | flush);
  assign mem_wb_result            = result;
  assign forward_reg_dest_addr    = ex_mem_inst[11:7];
  assign forward_reg_write_data   = result;
  assign forward_reg_write_enable = mem_wb_valid & writes_rd & ~trap_q & (ex_mem_inst[11:7] != 5'd0);

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ex_mem_inst;
  logic [63:0] ex_mem_inst_pc;
  logic        ex_mem_valid;
  logic [63:0] ex_mem_alu_result;
  logic [63:0] ex_mem_write_mem_data;
  logic        advance;
  logic        flush;
  logic [31:0] mem_wb_inst;
  logic [63:0] mem_wb_inst_pc;
  logic        mem_wb_valid;
  logic [63:0] mem_wb_result;
  logic        forward_reg_write_enable;
  logic [4:0]  forward_reg_dest_addr;
  logic [63:0] forward_reg_write_data;
  logic        ok;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADD = 32'h0000_02B3;
  localparam logic [31:0] I_LB  = 32'h0000_0303;
  localparam logic [31:0] I_LHU = 32'h0000_5383;
  localparam logic [31:0] I_SW  = 32'h0000_2023;
  localparam logic [31:0] I_LD  = 32'h0000_3403;
  localparam logic [31:0] I_LW  = 32'h0000_2483;

  always #5 clk = ~clk;

  mem_access dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .ex_mem_inst              (ex_mem_inst),
    .ex_mem_inst_pc           (ex_mem_inst_pc),
    .ex_mem_valid             (ex_mem_valid),
    .ex_mem_alu_result        (ex_mem_alu_result),
    .ex_mem_write_mem_data    (ex_mem_write_mem_data),
    .advance                  (advance),
    .flush                    (flush),
    .mem_wb_inst              (mem_wb_inst),
    .mem_wb_inst_pc           (mem_wb_inst_pc),
    .mem_wb_valid             (mem_wb_valid),
    .mem_wb_result            (mem_wb_result),
    .forward_reg_write_enable (forward_reg_write_enable),
    .forward_reg_dest_addr    (forward_reg_dest_addr),
    .forward_reg_write_data   (forward_reg_write_data),
    .ok                       (ok),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign                 (misalign),
`endif
    .dreq_valid               (dreq_valid),
    .dreq_addr                (dreq_addr),
    .dreq_size                (dreq_size),
    .dreq_strobe              (dreq_strobe),
    .dreq_data                (dreq_data),
    .dresp_data_ok            (dresp_data_ok),
    .dresp_data               (dresp_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && advance === 1'b1) begin
      n_checks++;
      assert (ok === 1'b1) else begin
        n_fail++;
        $error("FAIL advance_without_ok observed=%b expected=1", ok);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ex_mem_inst = '0;
    ex_mem_inst_pc = 64'h8000_0000;
    ex_mem_valid = 1'b0;
    ex_mem_alu_result = '0;
    ex_mem_write_mem_data = '0;
    advance = 1'b0;
    flush = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ok", ok, 0);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_dreq_addr", dreq_addr, 0);
    check("rst_wb_valid", mem_wb_valid, 0);

    // ADD pass-through: zero latency
    rst_n = 1'b1;
    ex_mem_valid = 1'b1;
    ex_mem_inst = I_ADD;
    ex_mem_alu_result = 64'h1234;
    #1;
    check("add_ok", ok, 1);
    check("add_dreq_valid", dreq_valid, 0);
    check("add_fwd_data", forward_reg_write_data, 64'h1234);
    check("add_fwd_en", forward_reg_write_enable, 1);
    check("add_fwd_rd", forward_reg_dest_addr, 5);
    check("add_wb_valid", mem_wb_valid, 1);
    advance = 1'b1;

    // LB 0x1003, response on the third WAIT cycle
    tick();
    advance = 1'b0;
    ex_mem_inst = I_LB;
    ex_mem_alu_result = 64'h1003;
    #1;
    check("lb_issue_valid", dreq_valid, 1);
    check("lb_issue_addr", dreq_addr, 64'h1003);
    check("lb_issue_strobe", dreq_strobe, 0);
    check("lb_issue_ok", ok, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin
        dresp_data_ok = 1'b1;
        dresp_data = 64'h0000_0000_8000_0000;
      end
      #1;
      check("lb_wait_valid", dreq_valid, 1);
      check("lb_wait_addr", dreq_addr, 64'h1003);
      check("lb_wait_size", dreq_size, 0);
      check("lb_wait_ok", ok, 0);
    end
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("lb_done_ok", ok, 1);
    check("lb_done_dreq_valid", dreq_valid, 0);
    check("lb_result", mem_wb_result, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_fwd_en", forward_reg_write_enable, 1);
    check("lb_wb_valid", mem_wb_valid, 1);
    advance = 1'b1;

    // LHU 0x2006 with an immediate response
    tick();
    advance = 1'b0;
    ex_mem_inst = I_LHU;
    ex_mem_alu_result = 64'h2006;
    dresp_data_ok = 1'b1;
    dresp_data = 64'hBEEF_0000_0000_0000;
    #1;
    check("lhu_issue_valid", dreq_valid, 1);
    check("lhu_issue_size", dreq_size, 1);
    check("lhu_issue_ok", ok, 0);
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("lhu_done_ok", ok, 1);
    check("lhu_result", mem_wb_result, 64'h0000_0000_0000_BEEF);
    advance = 1'b1;

    // SW 0x3004
    tick();
    advance = 1'b0;
    ex_mem_inst = I_SW;
    ex_mem_alu_result = 64'h3004;
    ex_mem_write_mem_data = 64'hDEAD_BEEF;
    #1;
    check("sw_issue_valid", dreq_valid, 1);
    check("sw_strobe", dreq_strobe, 8'hF0);
    check("sw_data", dreq_data, 64'hDEAD_BEEF_0000_0000);
    check("sw_size", dreq_size, 2);
    tick();
    dresp_data_ok = 1'b1;
    #1;
    check("sw_wait_strobe", dreq_strobe, 8'hF0);
    check("sw_wait_data", dreq_data, 64'hDEAD_BEEF_0000_0000);
    check("sw_wait_ok", ok, 0);
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("sw_done_ok", ok, 1);
    check("sw_result", mem_wb_result, 64'h3004);
    check("sw_fwd_en", forward_reg_write_enable, 0);
    check("sw_wb_valid", mem_wb_valid, 1);
    advance = 1'b1;

    // LD 0x5000 flushed while waiting; request must stay up until data_ok
    tick();
    advance = 1'b0;
    ex_mem_inst = I_LD;
    ex_mem_alu_result = 64'h5000;
    #1;
    check("ldf_issue_valid", dreq_valid, 1);
    tick();
    flush = 1'b1;
    #1;
    check("ldf_flush_valid", dreq_valid, 1);
    check("ldf_flush_wb", mem_wb_valid, 0);
    tick();
    flush = 1'b0;
    ex_mem_valid = 1'b0;
    #1;
    check("ldf_hold_valid", dreq_valid, 1);
    check("ldf_hold_addr", dreq_addr, 64'h5000);
    check("ldf_hold_wb", mem_wb_valid, 0);
    tick();
    dresp_data_ok = 1'b1;
    dresp_data = 64'h0123_4567_89AB_CDEF;
    #1;
    check("ldf_resp_valid", dreq_valid, 1);
    check("ldf_resp_ok", ok, 0);
    check("ldf_resp_wb", mem_wb_valid, 0);
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("ldf_after_dreq", dreq_valid, 0);
    check("ldf_after_wb", mem_wb_valid, 0);
    check("ldf_after_fwd_en", forward_reg_write_enable, 0);

    // LD 0x6008 interrupted by reset in WAIT, then reissued
    tick();
    ex_mem_valid = 1'b1;
    ex_mem_inst = I_LD;
    ex_mem_alu_result = 64'h6008;
    #1;
    check("ldr_issue_valid", dreq_valid, 1);
    tick();
    #1;
    check("ldr_wait_valid", dreq_valid, 1);
    rst_n = 1'b0;
    #1;
    check("ldr_rst_dreq", dreq_valid, 0);
    check("ldr_rst_ok", ok, 0);
    tick();
    rst_n = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 64'h1122_3344_5566_7788;
    #1;
    check("ldr_reissue_valid", dreq_valid, 1);
    check("ldr_reissue_addr", dreq_addr, 64'h6008);
    check("ldr_reissue_size", dreq_size, 3);
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("ldr_done_ok", ok, 1);
    check("ldr_result", mem_wb_result, 64'h1122_3344_5566_7788);
    check("ldr_fwd_en", forward_reg_write_enable, 1);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    ex_mem_valid = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
    // LW 0x4002 traps without touching the bus
    ex_mem_valid = 1'b1;
    ex_mem_inst = I_LW;
    ex_mem_alu_result = 64'h4002;
    #1;
    check("mis_dreq_valid", dreq_valid, 0);
    check("mis_issue_ok", ok, 0);
    tick();
    #1;
    check("mis_flag", misalign, 1);
    check("mis_ok", ok, 1);
    check("mis_dreq_after", dreq_valid, 0);
    check("mis_wb_valid", mem_wb_valid, 1);
    check("mis_fwd_en", forward_reg_write_enable, 0);
    check("mis_result", mem_wb_result, 64'h4002);
    advance = 1'b1;
    tick();
    advance = 1'b0;
    ex_mem_valid = 1'b0;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the in-order pipeline; consumes the ex_mem register produced by execute.
- Issues load/store transactions on the data bus and holds them until the bus responds.
- Aligns and extends load data; produces the mem_wb state and a reg_writer forward record.
- Reports completion through ok so the hazard/stall logic can advance the pipeline.

Parameters:
- XLEN, 64, data/address width.
- ADDR_MASK_LSB, 3, number of byte-offset bits within a word (log2(XLEN/8)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_mem_state  in  ex_mem  inst, inst_pc, valid, alu_result (address or ALU value), write_mem_data.
- advance  in  1  pipeline register downstream captures this cycle.
- flush  in  1  discard the current instruction.
- mem_wb_state  out  mem_wb  inst, inst_pc, valid, result.
- forward  out  reg_writer  reg_write_enable, reg_dest_addr, reg_write_data.
- ok  out  1  stage result valid this cycle.
- dreq_valid  out  1  data request valid.
- dreq_addr  out  XLEN  byte address, unaligned as computed.
- dreq_size  out  3  0=byte, 1=half, 2=word, 3=double.
- dreq_strobe  out  XLEN/8  byte write enables; all zero for loads.
- dreq_data  out  XLEN  store data shifted to lane.
- dresp_data_ok  in  1  response for the outstanding request.
- dresp_data  in  XLEN  full aligned word read.

Behaviour:
- Classification:
  - opcode inst[6:0] 0000011 = load; 0100011 = store; anything else = pass-through.
  - funct3 inst[14:12] selects size: 0/4=B, 1/5=H, 2/6=W, 3=D. Values 4-6 are zero-extending loads; 0-2 are sign-extending.
- Lane: off = alu_result[2:0].
  - Store: strobe = size mask (0x01/0x03/0x0F/0xFF) << off, truncated to 8 bits; dreq_data = write_mem_data << (8*off).
  - Load: result = extend((dresp_data >> 8*off) truncated to size).
- FSM states IDLE, WAIT, DONE. Reset: IDLE, dreq_valid=0, all dreq_* outputs 0, load buffer 0, ok=0.
- IDLE:
  - valid and memory op and not flush: assert dreq_valid combinationally, go to WAIT.
  - If dresp_data_ok is already high in the same cycle: capture data, go to DONE.
  - Otherwise (pass-through or invalid): ok=1 combinationally, result=alu_result.
- WAIT:
  - dreq_valid=1; dreq_addr, size, strobe and data must stay stable from registered copies.
  - On dresp_data_ok: latch the aligned/extended load data, go to DONE.
- DONE:
  - ok=1; dreq_valid=0; result = latched data for loads, alu_result for stores.
  - advance=1: go to IDLE.
- Latency:
  - Pass-through: 0 cycles.
  - Memory op: ok asserts the cycle after dresp_data_ok (minimum 1 cycle when data_ok is immediate).
- Flush:
  - In IDLE: nothing issued.
  - In WAIT: the request must not be withdrawn. Keep dreq_valid until data_ok, then return to IDLE without ok, mark the entry as killed, and deassert valid on mem_wb_state.
  - In DONE: return to IDLE next cycle with no write-back.
- mem_wb_state:
  - inst and inst_pc pass through.
  - valid = ex valid & ok & not killed.
  - result as above.
- forward:
  - reg_dest_addr = inst[11:7]; reg_write_data = result.
  - reg_write_enable = mem_wb_state.valid & (load or arith-writing op) & rd≠0.
- advance while ok=0 is illegal; the bench asserts it never happens.
- Async reset mid-WAIT: immediately IDLE, dreq_valid=0. The bus is reset by the same rst_n.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access is detected: H with off[0]=1, W with off[1:0]≠0, D with off≠0.
  - No bus request is issued; the stage goes straight to DONE with valid=1, reg_write_enable=0.
  - Extra output misalign (1 bit) is asserted in DONE and carries the address in result.
- Undefined:
  - No check; the address is issued as-is.
  - Lane shift truncates bytes past bit 63; no misalign port exists.

Test Plan:
- ADD pass-through, alu_result=0x1234 -> ok=1 same cycle, dreq_valid=0, forward data 0x1234 enable=1.
- LB addr 0x1003, data_ok after 3 cycles with dresp_data=0x0000_0000_8000_0000 -> dreq_valid held with stable addr 3 cycles; ok the cycle after data_ok; result 0xFFFF_FFFF_FFFF_FF80.
- LHU addr 0x2006, dresp_data=0xBEEF_0000_0000_0000 -> result 0x0000_0000_0000_BEEF.
- SW addr 0x3004, write_mem_data=0xDEADBEEF -> dreq_strobe=0xF0, dreq_data=0xDEADBEEF_0000_0000, size=2, forward enable=0.
- LD with flush pulsed in WAIT, data_ok 2 cycles later -> dreq_valid held until data_ok, then IDLE; mem_wb valid never 1.
- rst_n low during WAIT -> dreq_valid=0 and ok=0 immediately; the next LD after release issues normally.
- With MEM_MISALIGN_TRAP_EN: LW addr 0x4002 -> no dreq_valid, misalign=1, ok=1 next cycle.
